ledr_pwm_driver: RTL and testbench
==================================

LEDR_PWM_DRIVER -- requirements
Module: ledr_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 49: PWM tick every PRESCALE+1 clocks; 0 means a tick every clock.
REQ-002 SHALL have parameter NLED, default 10: number of LED channels.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe; write = chipselect && !write_n.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  read data, combinational from address, zero wait states, unused bits 0.
REQ-010 led_pattern  input  NLED  LED on/off pattern from the upstream LEDR PIO out_port.
REQ-011 ledr  output  NLED  registered drive to board LEDs, 1 = lit.

Function
REQ-012 Register map SHALL be: 0 DUTY[7:0] RW; 1 BLINK[15:0] RW (PWM periods per half-cycle, 0 = no blink); 2 CTRL RW (bit0 enable, bit1 invert); 3 STATUS RO (bit0 blink_phase, bits[15:8] pwm_cnt).
REQ-013 Writes to address 3 SHALL be ignored; only the listed bits of each register SHALL be stored.
REQ-014 Prescaler SHALL count 0..PRESCALE and assert a one-clock tick on the clock where it equals PRESCALE, then wrap to 0.
REQ-015 8-bit pwm_cnt SHALL increment on each tick and wrap 255->0; a period boundary is the tick on which pwm_cnt wraps to 0.
REQ-016 At each period boundary, shadow_pattern SHALL load led_pattern and shadow_duty SHALL load DUTY; neither SHALL change at any other time.
REQ-017 pwm_on SHALL be 1 when shadow_duty == 255, else (pwm_cnt < shadow_duty); duty 0 SHALL give 0.
REQ-018 16-bit blink_cnt SHALL increment at each period boundary while BLINK != 0; when blink_cnt == BLINK-1 at a boundary it SHALL clear to 0 and blink_phase SHALL toggle.
REQ-019 A write to BLINK SHALL clear blink_cnt and set blink_phase = 1 on the same clock, overriding any simultaneous boundary update.
REQ-020 blink_on SHALL be 1 when BLINK == 0, else blink_phase.
REQ-021 raw[i] SHALL be shadow_pattern[i] & pwm_on & blink_on; ledr SHALL register (raw XOR {NLED{invert}}) when enable = 1, and all-zero when enable = 0 regardless of invert.
REQ-022 ledr SHALL reflect internal state with exactly one clock latency.
REQ-023 Register writes SHALL take effect on the clock after the write; DUTY reaches the output only via REQ-016.

Reset
REQ-024 On reset_n low, asynchronously: DUTY = 8'hFF, BLINK = 0, enable = 1, invert = 0, prescaler = 0, pwm_cnt = 0, blink_cnt = 0, blink_phase = 1, shadow_pattern = 0, shadow_duty = 8'hFF, ledr = 0.
REQ-025 Reset asserted mid-period or mid-blink SHALL abandon the period; after release, the first shadow load occurs at the first period boundary (256*(PRESCALE+1) clocks later).

Structure
REQ-026 Register address constants (0..3), CTRL bit indices, and reset values SHALL live in a shared package ledr_pwm_pkg.
REQ-027 The prescaler + pwm_cnt + boundary generation SHALL be one sub-module, ledr_pwm_timebase, outputting tick, boundary and pwm_cnt; all else in ledr_pwm_driver.

Verification
REQ-028 Reset defaults: PRESCALE=0, led_pattern=10'h3FF, no writes -> ledr 0 for 256 clocks, then 10'h3FF continuously after the first boundary; readdata at address 0 = 0xFF.
REQ-029 Duty: PRESCALE=0, DUTY=64, pattern 10'h001 -> after next boundary, ledr[0] high exactly 64 of every 256 clocks, other bits 0; DUTY=0 -> ledr[0] stays 0.
REQ-030 Pattern glitch-free: change led_pattern 10'h0F0->10'h00F mid-period -> ledr keeps 10'h0F0 gating until the boundary, switches exactly one clock after it.
REQ-031 Blink: PRESCALE=0, DUTY=255, BLINK=2 -> ledr alternates 512 clocks lit / 512 clocks dark; STATUS bit0 toggles in step; writing BLINK=0 restores steady lit.
REQ-032 CTRL: enable=1, invert=1, pattern 10'h000 -> ledr 10'h3FF; enable=0 -> ledr 10'h000 one clock later; write to address 3 -> no register change.
REQ-033 Async reset mid-blink: assert reset_n for 3 clocks while blink_phase = 0 -> ledr 0 immediately, all registers at REQ-024 values on release.

Source files
------------

// File: rtl/ledr_pwm_pkg.sv
// Shared constants for the LEDR PWM driver: register map, CTRL bits,
// and reset values.
package ledr_pwm_pkg;

   localparam logic [1:0] ADDR_DUTY   = 2'd0;
   localparam logic [1:0] ADDR_BLINK  = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_INV = 1;

   localparam logic [7:0]  PWM_MAX     = 8'hFF;
   localparam logic [7:0]  DUTY_RST    = 8'hFF;
   localparam logic [15:0] BLINK_RST   = 16'h0000;
   localparam logic        EN_RST      = 1'b1;
   localparam logic        INV_RST     = 1'b0;
   localparam logic        PHASE_RST   = 1'b1;

   function automatic logic pwm_gate(input logic [7:0] cnt,
                                     input logic [7:0] duty);
      return (duty == PWM_MAX) || (cnt < duty);
   endfunction

endpackage

// File: rtl/ledr_pwm_timebase.sv
// Prescaler and 8-bit PWM counter; flags the tick on which the
// counter wraps as the period boundary.
module ledr_pwm_timebase
   import ledr_pwm_pkg::*;
#(
   parameter int PRESCALE = 49
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       tick,
   output logic       boundary,
   output logic [7:0] pwm_cnt
);

   localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE);

   logic [PW-1:0] presc;

   assign tick     = (presc == PMAX);
   assign boundary = tick && (pwm_cnt == PWM_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick)
            pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/ledr_pwm_driver.sv
// Avalon-MM controlled PWM dimmer/blinker between the LEDR PIO and the
// board LEDs; pattern and duty only change at PWM period boundaries.
module ledr_pwm_driver
   import ledr_pwm_pkg::*;
#(
   parameter int PRESCALE = 49,
   parameter int NLED     = 10
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      address,
   input  logic            chipselect,
   input  logic            write_n,
   input  logic [31:0]     writedata,
   output logic [31:0]     readdata,
   input  logic [NLED-1:0] led_pattern,
   output logic [NLED-1:0] ledr
);

   logic            tick;
   logic            boundary;
   logic [7:0]      pwm_cnt;

   logic [7:0]      duty;
   logic [15:0]     blink;
   logic            enable;
   logic            invert;
   logic [15:0]     blink_cnt;
   logic            blink_phase;
   logic [NLED-1:0] shadow_pattern;
   logic [7:0]      shadow_duty;

   logic            wr;
   logic            blink_wr;
   logic            pwm_on;
   logic            blink_on;
   logic [NLED-1:0] raw;
   logic            unused;

   ledr_pwm_timebase #(
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .boundary (boundary),
      .pwm_cnt  (pwm_cnt)
   );

   assign wr       = chipselect && !write_n;
   assign blink_wr = wr && (address == ADDR_BLINK);
   assign pwm_on   = pwm_gate(pwm_cnt, shadow_duty);
   assign blink_on = (blink == 16'd0) || blink_phase;
   assign raw      = shadow_pattern & {NLED{pwm_on & blink_on}};
   assign unused   = ^{tick, writedata[31:16]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty   <= DUTY_RST;
         blink  <= BLINK_RST;
         enable <= EN_RST;
         invert <= INV_RST;
      end else if (wr) begin
         unique case (address)
            ADDR_DUTY:  duty  <= writedata[7:0];
            ADDR_BLINK: blink <= writedata[15:0];
            ADDR_CTRL: begin
               enable <= writedata[CTRL_EN];
               invert <= writedata[CTRL_INV];
            end
            default: ;
         endcase
      end
   end

   // A BLINK write restarts the blink cycle lit, even on a boundary.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= PHASE_RST;
      end else if (blink_wr) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (boundary && (blink != 16'd0)) begin
         if (blink_cnt == blink - 16'd1) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_pattern <= '0;
         shadow_duty    <= DUTY_RST;
      end else if (boundary) begin
         shadow_pattern <= led_pattern;
         shadow_duty    <= duty;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ledr <= '0;
      else if (enable)
         ledr <= raw ^ {NLED{invert}};
      else
         ledr <= '0;
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_DUTY:   readdata = {24'd0, duty};
         ADDR_BLINK:  readdata = {16'd0, blink};
         ADDR_CTRL:   readdata = {30'd0, invert, enable};
         ADDR_STATUS: readdata = {16'd0, pwm_cnt, 7'd0, blink_phase};
         default:     readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_ledr_pwm_driver.sv
// Directed bench for ledr_pwm_driver (PRESCALE=0): expectations are
// queued by the stimulus and checked by a negedge monitor.
module tb_ledr_pwm_driver;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  led_pattern;
   logic [9:0]  ledr;

   int cyc = 0;
   int total = 0;
   int passed = 0;

   bit          kind_q[$];
   logic [31:0] exp_q[$];
   string       name_q[$];

   ledr_pwm_driver #(
      .PRESCALE (0),
      .NLED     (10)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .led_pattern (led_pattern),
      .ledr        (ledr)
   );

   always #5 clk = ~clk;

   // Clocks since the last reset release; equals pwm_cnt when PRESCALE=0.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      while (kind_q.size() > 0) begin
         bit          k;
         logic [31:0] e;
         logic [31:0] a;
         string       n;
         k = kind_q.pop_front();
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = k ? readdata : {22'd0, ledr};
         total++;
         if (a === e) passed++;
         else $display("FAIL %s @cyc %0d: got %h want %h", n, cyc, a, e);
      end
   end

   task automatic chk_ledr(input logic [9:0] e, input string n);
      kind_q.push_back(1'b0);
      exp_q.push_back({22'd0, e});
      name_q.push_back(n);
   endtask

   task automatic chk_rd(input logic [1:0] a, input logic [31:0] e,
                         input string n);
      address = a;
      kind_q.push_back(1'b1);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic goto(input int n);
      int guard = 0;
      while (cyc < n && guard < 4000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cyc != n) begin
         total++;
         $display("FAIL goto: cyc %0d want %0d", cyc, n);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      clk = 0; reset_n = 1; address = 0; chipselect = 0;
      write_n = 1; writedata = 0; led_pattern = 10'h3FF;
      #2 reset_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_ledr(10'h000, "rst_ledr");
      chk_rd(2'd0, 32'hFF, "rst_duty"); sample();
      chk_rd(2'd1, 32'h0, "rst_blink"); sample();
      chk_rd(2'd2, 32'h1, "rst_ctrl"); sample();
      chk_rd(2'd3, 32'h1, "rst_status"); sample();
      reset_n = 1;

      goto(1);   chk_ledr(10'h000, "dflt_early"); sample();
      goto(256); chk_ledr(10'h000, "dflt_pre"); sample();
      goto(257); chk_ledr(10'h3FF, "dflt_lit"); sample();
      goto(300); chk_ledr(10'h3FF, "dflt_hold");
      chk_rd(2'd3, 32'h2C01, "status_cnt"); sample();

      led_pattern = 10'h001;
      wr(2'd0, 32'd64);
      chk_rd(2'd0, 32'd64, "duty_rd"); sample();
      goto(512); chk_ledr(10'h3FF, "duty_defer"); sample();
      for (int k = 513; k <= 768; k++) begin
         goto(k);
         chk_ledr((((k - 1) % 256) < 64) ? 10'h001 : 10'h000, "duty64");
         sample();
      end
      wr(2'd0, 32'd0);
      for (int k = 1024; k <= 1090; k++) begin
         goto(k); chk_ledr(10'h000, "duty0"); sample();
      end
      led_pattern = 10'h0F0;
      wr(2'd0, 32'd255);
      goto(1280); chk_ledr(10'h000, "duty0_end"); sample();
      goto(1281); chk_ledr(10'h0F0, "pat_load"); sample();

      goto(1400);
      led_pattern = 10'h00F;
      chk_ledr(10'h0F0, "pat_hold0"); sample();
      goto(1500); chk_ledr(10'h0F0, "pat_hold1"); sample();
      goto(1536); chk_ledr(10'h0F0, "pat_bnd"); sample();
      goto(1537); chk_ledr(10'h00F, "pat_new"); sample();

      led_pattern = 10'h000;
      goto(1599);
      wr(2'd2, 32'd3);
      chk_ledr(10'h00F, "ctrl_lat");
      chk_rd(2'd2, 32'd3, "ctrl_rd"); sample();
      goto(1601); chk_ledr(10'h3F0, "inv_raw"); sample();
      goto(1792); chk_ledr(10'h3F0, "inv_pre"); sample();
      goto(1793); chk_ledr(10'h3FF, "inv_zero"); sample();
      wr(2'd2, 32'd0);
      chk_ledr(10'h3FF, "dis_lat"); sample();
      goto(1795);
      chk_ledr(10'h000, "dis_off");
      chk_rd(2'd2, 32'd0, "dis_rd"); sample();
      wr(2'd3, 32'h0000_0002);
      chk_rd(2'd0, 32'hFF, "ro_duty"); sample();
      chk_rd(2'd1, 32'h0, "ro_blink"); sample();
      chk_rd(2'd2, 32'h0, "ro_ctrl"); sample();
      wr(2'd2, 32'd1);
      led_pattern = 10'h3FF;

      goto(1999);
      wr(2'd1, 32'd2);
      chk_ledr(10'h000, "blk_start");
      chk_rd(2'd3, 32'hD001, "blk_stat0"); sample();
      chk_rd(2'd1, 32'd2, "blk_rd"); sample();
      goto(2049); chk_ledr(10'h3FF, "blk_lit0"); sample();
      goto(2304);
      chk_ledr(10'h3FF, "blk_lit_end");
      chk_rd(2'd3, 32'h0000, "blk_stat1"); sample();
      goto(2305); chk_ledr(10'h000, "blk_dark0"); sample();
      goto(2600);
      chk_ledr(10'h000, "blk_dark_mid");
      chk_rd(2'd3, 32'h2800, "blk_stat2"); sample();
      goto(2816);
      chk_ledr(10'h000, "blk_dark_end");
      chk_rd(2'd3, 32'h0001, "blk_stat3"); sample();
      goto(2817); chk_ledr(10'h3FF, "blk_lit1"); sample();
      goto(3328); chk_ledr(10'h3FF, "blk_lit1_end"); sample();
      goto(3329); chk_ledr(10'h000, "blk_dark1"); sample();

      goto(3399);
      wr(2'd2, 32'd3);
      chk_ledr(10'h000, "blk_inv_lat"); sample();
      goto(3401); chk_ledr(10'h3FF, "blk_inv"); sample();
      goto(3402);
      reset_n = 0;
      chk_ledr(10'h000, "arst_ledr");
      chk_rd(2'd3, 32'h0001, "arst_status"); sample();
      chk_rd(2'd0, 32'hFF, "arst_duty"); sample();
      chk_rd(2'd2, 32'h1, "arst_ctrl"); sample();
      reset_n = 1;
      chk_rd(2'd1, 32'h0, "arst_blink"); sample();
      chk_rd(2'd3, 32'h0201, "arst_stat2"); sample();

      goto(100); chk_ledr(10'h000, "rel_early"); sample();
      goto(256); chk_ledr(10'h000, "rel_pre"); sample();
      goto(257); chk_ledr(10'h3FF, "rel_load"); sample();
      goto(299);
      wr(2'd1, 32'd1);
      goto(512); chk_ledr(10'h3FF, "b1_lit"); sample();
      goto(513);
      chk_ledr(10'h000, "b1_dark");
      chk_rd(2'd3, 32'h0100, "b1_stat"); sample();
      goto(599);
      wr(2'd1, 32'd0);
      chk_ledr(10'h000, "unblink_lat");
      chk_rd(2'd3, 32'h5801, "unblink_stat"); sample();
      goto(601); chk_ledr(10'h3FF, "unblink_on"); sample();
      goto(800); chk_ledr(10'h3FF, "steady0"); sample();
      goto(1200); chk_ledr(10'h3FF, "steady1"); sample();

      sample();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
